// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction memory port, decode handshake, redirect input, status outputs.
// Handshake: valid_o/instr_o/pc_o are held stable while valid_o && !ready_i; a transfer occurs on every edge with valid_o && ready_i.
interface instr_fetch_if;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        fault_o;
  logic [31:0] fetch_cnt_o;

  modport master (
    output imem_addr_o,
    input  imem_data_i,
    output valid_o,
    input  ready_i,
    output instr_o,
    output pc_o,
    input  redirect_i,
    input  redirect_pc_i,
    output fault_o,
    output fetch_cnt_o
  );

  modport slave (
    input  imem_addr_o,
    output imem_data_i,
    input  valid_o,
    output ready_i,
    input  instr_o,
    input  pc_o,
    output redirect_i,
    output redirect_pc_i,
    input  fault_o,
    input  fetch_cnt_o
  );
endinterface

// File: rtl/instr_fetch.sv
// Single-slot instruction fetch stage with redirect, sticky fault on misaligned target or
// fetch past the end of instruction memory, and a count of accepted instructions.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_fetch_if.master        bus,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic [31:0] r_cnt;
  logic        r_valid;
  logic        r_fault;

  logic w_hs;
  logic w_misaligned;
  logic w_out_of_range;
  logic w_can_load;
  logic w_load;
  logic w_redir;
  logic w_drop;
  logic w_enter_fault;
  logic w_clear_fault;

  assign w_hs           = r_valid & bus.ready_i;
  assign w_misaligned   = |bus.redirect_pc_i[1:0];
  assign w_out_of_range = (r_pc[31:2] >= IMEM_LIMIT);
  assign w_can_load     = !r_valid || bus.ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= BOOT;
    else        r_state <= w_next;
  end

  // Redirect outranks both load and stall; the out-of-range test only fires when a load
  // would otherwise happen, so a valid in-range instruction still completes its handshake.
  always_comb begin
    w_next        = r_state;
    w_load        = 1'b0;
    w_redir       = 1'b0;
    w_drop        = 1'b0;
    w_enter_fault = 1'b0;
    w_clear_fault = 1'b0;
    case (r_state)
      BOOT, RUN: begin
        w_next = RUN;
        if (bus.redirect_i) begin
          w_drop = 1'b1;
          if (w_misaligned) begin
            w_next        = FAULT;
            w_enter_fault = 1'b1;
          end else begin
            w_redir = 1'b1;
          end
        end else if (w_can_load) begin
          if (w_out_of_range) begin
            w_next        = FAULT;
            w_enter_fault = 1'b1;
            w_drop        = 1'b1;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      FAULT: begin
        if (bus.redirect_i && !w_misaligned) begin
          w_next        = RUN;
          w_redir       = 1'b1;
          w_clear_fault = 1'b1;
        end
      end
      default: w_next = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_instr  <= 32'h0;
      r_pc_out <= 32'h0;
      r_cnt    <= 32'h0;
      r_valid  <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      if (w_hs) r_cnt <= r_cnt + 32'd1;
      if (w_redir)     r_pc <= bus.redirect_pc_i;
      else if (w_load) r_pc <= r_pc + 32'd4;
      if (w_load) begin
        r_instr  <= bus.imem_data_i;
        r_pc_out <= r_pc;
        r_valid  <= 1'b1;
      end else if (w_drop) begin
        r_valid <= 1'b0;
      end
      if (w_enter_fault)      r_fault <= 1'b1;
      else if (w_clear_fault) r_fault <= 1'b0;
    end
  end

  assign bus.imem_addr_o = {2'b00, r_pc[31:2]};
  assign bus.valid_o     = r_valid;
  assign bus.instr_o     = r_instr;
  assign bus.pc_o        = r_pc_out;
  assign bus.fault_o     = r_fault;
  assign bus.fetch_cnt_o = r_cnt;
  assign o_dbg_state     = r_state;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: byte address fetched first after reset.
REQ-002 Parameter IMEM_WORDS, default 13: number of valid 32-bit words in instruction memory, indices 0..IMEM_WORDS-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 imem_addr_o  output  32  word index to instruction memory, equal to pc[31:2] zero-extended.
REQ-006 imem_data_i  input  32  instruction word, combinationally valid in the same cycle as imem_addr_o.
REQ-007 valid_o  output  1  instr_o/pc_o hold a fetched instruction.
REQ-008 ready_i  input  1  decode accepts instr_o this cycle.
REQ-009 instr_o  output  32  registered instruction word.
REQ-010 pc_o  output  32  byte address of instr_o.
REQ-011 redirect_i  input  1  branch/jump redirect request.
REQ-012 redirect_pc_i  input  32  redirect target byte address.
REQ-013 fault_o  output  1  sticky fetch fault flag.
REQ-014 fetch_cnt_o  output  32  count of completed handshakes (valid_o && ready_i).

Function
REQ-015 Internal pc register SHALL hold the next byte address to fetch; imem_addr_o SHALL be pc>>2 at all times.
REQ-016 FSM states SHALL be BOOT, RUN, FAULT; reset enters BOOT; BOOT -> RUN unconditionally after one cycle.
REQ-017 In BOOT and RUN, output register SHALL load when (!valid_o || ready_i) and no redirect: instr_o<=imem_data_i, pc_o<=pc, valid_o<=1, pc<=pc+4 (32-bit wrap).
REQ-018 When valid_o && !ready_i and no redirect, instr_o, pc_o, valid_o and pc SHALL hold.
REQ-019 Redirect SHALL take priority over load and stall: pc<=redirect_pc_i, valid_o<=0 at that edge; the held instruction is discarded and not counted.
REQ-020 Redirect latency: redirect_i high in cycle N SHALL give valid_o=1 with pc_o=redirect_pc_i in cycle N+2, if ready_i does not matter for the flushed slot.
REQ-021 Redirect with redirect_pc_i[1:0]!=0 SHALL enter FAULT: valid_o<=0, fault_o<=1, pc unchanged.
REQ-022 A load with pc[31:2] >= IMEM_WORDS SHALL not occur; instead FSM enters FAULT, valid_o<=0, fault_o<=1, pc held; an already valid in-range instruction in the output register SHALL first complete its handshake.
REQ-023 In FAULT, no loads SHALL occur and valid_o SHALL stay 0; an aligned redirect SHALL return to RUN with pc<=redirect_pc_i and clear fault_o; a misaligned redirect SHALL stay in FAULT.
REQ-024 fetch_cnt_o SHALL increment by 1 (32-bit wrap) on each cycle with valid_o && ready_i, including the redirect cycle if valid_o && ready_i then.
REQ-025 Simultaneous redirect and handshake: the handshake SHALL count, and the redirect SHALL still apply per REQ-019.

Reset
REQ-026 rst_n low at a rising edge SHALL set pc=RESET_PC, valid_o=0, instr_o=0, pc_o=0, fault_o=0, fetch_cnt_o=0, state BOOT, overriding all other inputs including redirect_i.
REQ-027 Reset asserted mid-stall or in FAULT SHALL discard the held instruction and restart from RESET_PC.

Verification
REQ-028 Reset release, ready_i=1, memory loaded with the nop/addi/sw/lw/blt test program -> cycle 0 valid_o=0, imem_addr_o=0; cycle 1 valid_o=1, pc_o=0, instr_o=0x00000013; cycle 2 pc_o=4, instr_o=0x00100093; cycle 3 pc_o=8, instr_o=0x00100313.
REQ-029 ready_i=0 for 3 cycles while pc_o=8 -> pc_o, instr_o stable, imem_addr_o=3, fetch_cnt_o unchanged; ready_i=1 -> next pc_o=0xC, instr_o=0x0060A023.
REQ-030 redirect_i=1, redirect_pc_i=0x14 in cycle N -> valid_o=0 in N+1; valid_o=1, pc_o=0x14, instr_o=0x0000A303 in N+2.
REQ-031 Free run from 0 with ready_i=1 -> pc_o=0x30, instr_o=0x00000013 accepted, then valid_o=0, fault_o=1, fetch_cnt_o=13; redirect to 0x0 -> fault_o=0, pc_o=0 two cycles later.
REQ-032 redirect_pc_i=0x6 -> fault_o=1, valid_o=0 next cycle; rst_n=0 one cycle -> fault_o=0, fetch_cnt_o=0, restart at pc 0.
